// File: rtl/readout_pkg.sv
// Shared definitions for the line-readout path: FSM state encoding and the
// pixel-window bounds, expressed as functions of the waveform period C.
package readout_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_TAIL = 2'd2,
        ST_DONE = 2'd3
    } line_state_t;

    localparam int PIX_CNT_W = 12;
    localparam int PIX_IDX_W = 11;

    // First generator pulse of the pixel window.
    function automatic logic [31:0] win_lo(input int c);
        return 32'(5 * c - 1);
    endfunction

    // End of the pixel window; counting continues past it to cover ADC latency.
    function automatic logic [31:0] win_hi(input int c);
        return 32'(2053 * c);
    endfunction

    function automatic logic [31:0] line_last(input int c);
        return 32'(2058 * c - 1);
    endfunction

endpackage

// File: rtl/readout_pixel_capture.sv
// Sample capture for one readout line: pixel counter, registered sample,
// and sticky overrun/underrun flags.
module readout_pixel_capture
    import readout_pkg::*;
#(
    parameter int N_PIXELS = 2048,
    parameter int ADC_W    = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 active,
    input  logic                 clear_flags,
    input  logic                 clear_count,
    input  logic                 line_end,
    input  logic                 adc_valid,
    input  logic [ADC_W-1:0]     adc_data,
    output logic                 pix_valid,
    output logic [ADC_W-1:0]     pix_data,
    output logic [PIX_IDX_W-1:0] pix_index,
    output logic                 overrun,
    output logic                 underrun
);

    localparam logic [PIX_CNT_W-1:0] N_MAX = PIX_CNT_W'(N_PIXELS);

    logic [PIX_CNT_W-1:0] pix_cnt;
    logic                 accept;
    logic                 count_short;

    assign accept      = active && adc_valid && (pix_cnt < N_MAX);
    // A sample accepted on the final cycle still counts toward the line.
    assign count_short = (pix_cnt + PIX_CNT_W'(accept)) < N_MAX;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt   <= '0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_index <= '0;
            overrun   <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            pix_valid <= accept;
            if (accept) begin
                pix_data  <= adc_data;
                pix_index <= pix_cnt[PIX_IDX_W-1:0];
            end
            if (clear_count) begin
                pix_cnt <= '0;
            end else if (accept) begin
                pix_cnt <= pix_cnt + PIX_CNT_W'(1);
            end
            if (clear_flags) begin
                overrun  <= 1'b0;
                underrun <= 1'b0;
            end else begin
                if (adc_valid && !accept) overrun <= 1'b1;
                if (line_end && count_short) underrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/readout_line_sequencer.sv
// Line-readout controller: drives the waveform generator counter/enable and
// captures ADC samples. READOUT_LINE_REPEAT_EN enables multi-line sequences.
module readout_line_sequencer
    import readout_pkg::*;
#(
    parameter int CICLOS_FORMAS_DE_ONDA = 8,
    parameter int N_PIXELS              = 2048,
    parameter int ADC_W                 = 12
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_start,
    input  logic                 i_abort,
`ifdef READOUT_LINE_REPEAT_EN
    input  logic [15:0]          i_num_lines,
    output logic [15:0]          o_line_idx,
`endif
    output logic                 o_enable,
    output logic [31:0]          o_contador,
    input  logic                 i_adc_valid,
    input  logic [ADC_W-1:0]     i_adc_data,
    output logic                 o_pix_valid,
    output logic [ADC_W-1:0]     o_pix_data,
    output logic [PIX_IDX_W-1:0] o_pix_index,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_overrun,
    output logic                 o_underrun,
    output line_state_t          o_state
);

    // Handshake: i_start is taken only in IDLE; o_busy rises the next cycle and
    // stays high through the one-cycle o_done pulse, dropping on return to IDLE.
    localparam logic [31:0] WIN_HI_M1 = win_hi(CICLOS_FORMAS_DE_ONDA) - 32'd1;
    localparam logic [31:0] LAST      = line_last(CICLOS_FORMAS_DE_ONDA);

    line_state_t state;
    logic        active;
    logic        accept_start;
    logic        line_end;
    logic        line_restart;

    assign active       = (state == ST_RUN) || (state == ST_TAIL);
    assign accept_start = (state == ST_IDLE) && i_start;
    assign line_end     = active && (i_abort || ((state == ST_TAIL) && (o_contador == LAST)));
    assign o_state      = state;

`ifdef READOUT_LINE_REPEAT_EN
    logic [15:0] line_idx;
    logic [15:0] lines_total;
    logic        seq_abort;

    assign lines_total  = (i_num_lines == 16'd0) ? 16'd1 : i_num_lines;
    assign line_restart = (state == ST_DONE) && !seq_abort && (line_idx < lines_total - 16'd1);
    assign o_line_idx   = line_idx;
`else
    assign line_restart = 1'b0;
`endif

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= ST_IDLE;
            o_enable   <= 1'b0;
            o_contador <= 32'd0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
`ifdef READOUT_LINE_REPEAT_EN
            line_idx   <= 16'd0;
            seq_abort  <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state      <= ST_RUN;
                        o_enable   <= 1'b1;
                        o_contador <= 32'd0;
                        o_busy     <= 1'b1;
`ifdef READOUT_LINE_REPEAT_EN
                        line_idx   <= 16'd0;
                        seq_abort  <= 1'b0;
`endif
                    end
                end
                ST_RUN, ST_TAIL: begin
                    if (line_end) begin
                        state      <= ST_DONE;
                        o_enable   <= 1'b0;
                        o_contador <= 32'd0;
                        o_done     <= 1'b1;
`ifdef READOUT_LINE_REPEAT_EN
                        seq_abort  <= i_abort;
`endif
                    end else begin
                        o_contador <= o_contador + 32'd1;
                        if ((state == ST_RUN) && (o_contador == WIN_HI_M1)) state <= ST_TAIL;
                    end
                end
                ST_DONE: begin
                    if (line_restart) begin
                        state      <= ST_RUN;
                        o_enable   <= 1'b1;
                        o_contador <= 32'd0;
`ifdef READOUT_LINE_REPEAT_EN
                        line_idx   <= line_idx + 16'd1;
`endif
                    end else begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    readout_pixel_capture #(
        .N_PIXELS (N_PIXELS),
        .ADC_W    (ADC_W)
    ) u_capture (
        .clk         (i_clock),
        .rst_n       (i_reset_n),
        .active      (active),
        .clear_flags (accept_start),
        .clear_count (accept_start | line_restart),
        .line_end    (line_end),
        .adc_valid   (i_adc_valid),
        .adc_data    (i_adc_data),
        .pix_valid   (o_pix_valid),
        .pix_data    (o_pix_data),
        .pix_index   (o_pix_index),
        .overrun     (o_overrun),
        .underrun    (o_underrun)
    );

endmodule

// File: tb/tb_readout_line_sequencer.sv
// Directed bench for readout_line_sequencer (C=8, 2048 pixels); exercises the
// READOUT_LINE_REPEAT_EN sequence when that macro is defined.
module tb_readout_line_sequencer;
  import readout_pkg::*;

  localparam int C         = 8;
  localparam int NP        = 2048;
  localparam int W         = 12;
  localparam int LINE_LAST = 2058 * C - 1;
  localparam int LINE_CYC  = LINE_LAST + 2;
  localparam int FIRST_SMP = 6 * C;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0, abort = 1'b0, adc_valid = 1'b0;
  logic [W-1:0] adc_data = '0;
  logic enable, pix_valid, busy, done, overrun, underrun;
  logic [31:0] contador;
  logic [W-1:0] pix_data;
  logic [10:0] pix_index;
  line_state_t state;
`ifdef READOUT_LINE_REPEAT_EN
  logic [15:0] num_lines = 16'd1;
  logic [15:0] line_idx;
`endif

  readout_line_sequencer #(
    .CICLOS_FORMAS_DE_ONDA(C), .N_PIXELS(NP), .ADC_W(W)
  ) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_start(start), .i_abort(abort),
`ifdef READOUT_LINE_REPEAT_EN
    .i_num_lines(num_lines), .o_line_idx(line_idx),
`endif
    .o_enable(enable), .o_contador(contador),
    .i_adc_valid(adc_valid), .i_adc_data(adc_data),
    .o_pix_valid(pix_valid), .o_pix_data(pix_data), .o_pix_index(pix_index),
    .o_busy(busy), .o_done(done), .o_overrun(overrun), .o_underrun(underrun),
    .o_state(state)
  );

  int n_checks = 0;
  int n_fail = 0;

  // scoreboard and per-run statistics
  logic [W-1:0] exp_q[$];
  int busy_cycles, done_cycles, pix_count, line_pix, pix_err, cnt_err;
  int last_index, extra_pv, extra_idx, extra_k, sent, line_k;
  int done_k[4];
  int done_line[4];
  logic finished;
  logic snap_enable, snap_busy, snap_done, snap_pv, snap_ovr, snap_und;
  logic [31:0] snap_cnt;
  logic [10:0] snap_idx;
  logic [W-1:0] snap_data;

  // driver: starts a line, models the ADC (one sample per pixel period) and
  // injects extra sample / abort / start / reset at given contador values
  task automatic run_line(input int extra_at, input int abort_at, input int start_at,
                          input int reset_at, input int budget);
    logic [W-1:0] d;
    int k;
    busy_cycles = 0; done_cycles = 0; pix_count = 0; line_pix = 0; pix_err = 0;
    cnt_err = 0; last_index = -1; extra_pv = -1; extra_idx = -1; extra_k = -1;
    sent = 0; line_k = 0; finished = 1'b0; exp_q.delete();
    for (int i = 0; i < 4; i++) begin done_k[i] = -1; done_line[i] = -1; end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (k < budget) begin
      start = 1'b0; abort = 1'b0; adc_valid = 1'b0;
      if (k > 0 && !busy) begin finished = 1'b1; break; end
      busy_cycles++;
      if (done) begin
        if (done_cycles < 4) begin
          done_k[done_cycles] = k;
`ifdef READOUT_LINE_REPEAT_EN
          done_line[done_cycles] = int'(line_idx);
`endif
        end
        done_cycles++;
      end else begin
        if (contador !== 32'(line_k) || enable !== 1'b1) cnt_err++;
      end
      if (enable && contador == 32'd0) begin sent = 0; line_pix = 0; end
      if (pix_valid) begin
        pix_count++;
        if (exp_q.size() == 0) pix_err++;
        else begin
          d = exp_q.pop_front();
          if (pix_data !== d || pix_index !== 11'(line_pix)) pix_err++;
        end
        line_pix++;
        last_index = int'(pix_index);
      end
      if (k == extra_k) begin extra_pv = int'(pix_valid); extra_idx = int'(pix_index); end
      if (enable && contador >= 32'(FIRST_SMP) && contador % C == 0 && sent < NP) begin
        adc_valid = 1'b1; adc_data = W'($urandom_range(0, 4095));
        exp_q.push_back(adc_data); sent++;
      end
      if (enable && contador == 32'(extra_at)) begin
        adc_valid = 1'b1; adc_data = W'($urandom_range(0, 4095)); extra_k = k + 1;
      end
      if (enable && contador == 32'(abort_at)) abort = 1'b1;
      if (enable && contador == 32'(start_at)) start = 1'b1;
      if (enable && contador == 32'(reset_at)) begin
        #1 rst_n = 1'b0;
        #1;
        snap_enable = enable; snap_busy = busy; snap_done = done; snap_pv = pix_valid;
        snap_ovr = overrun; snap_und = underrun; snap_cnt = contador;
        snap_idx = pix_index; snap_data = pix_data;
        finished = 1'b1;
        break;
      end
      k++;
      line_k = done ? 0 : line_k + 1;
      @(negedge clk);
    end
    start = 1'b0; abort = 1'b0; adc_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks++; if (enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++;
      $display("FAIL reset_ctrl: enable=%b busy=%b done=%b, required 0", enable, busy, done); end
    n_checks++; if (contador !== 32'd0) begin n_fail++;
      $display("FAIL reset_contador: got %0d required 0", contador); end
    n_checks++; if (pix_valid !== 1'b0 || pix_index !== 11'd0 || pix_data !== '0) begin n_fail++;
      $display("FAIL reset_pix: valid=%b idx=%0d data=%0h, required 0", pix_valid, pix_index, pix_data); end
    n_checks++; if (overrun !== 1'b0 || underrun !== 1'b0) begin n_fail++;
      $display("FAIL reset_flags: ovr=%b und=%b, required 0", overrun, underrun); end
    n_checks++; if (state !== ST_IDLE) begin n_fail++;
      $display("FAIL reset_state: got %0d required IDLE", state); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_line();
    run_line(-1, -1, -1, -1, LINE_CYC + 100);
    n_checks++; if (finished !== 1'b1) begin n_fail++; $display("FAIL single_timeout: line did not end"); end
    n_checks++; if (busy_cycles !== LINE_CYC) begin n_fail++;
      $display("FAIL single_busy_len: got %0d required %0d", busy_cycles, LINE_CYC); end
    n_checks++; if (done_cycles !== 1 || done_k[0] !== LINE_CYC - 1) begin n_fail++;
      $display("FAIL single_done: count=%0d at=%0d required 1 at %0d", done_cycles, done_k[0], LINE_CYC - 1); end
    n_checks++; if (cnt_err !== 0) begin n_fail++;
      $display("FAIL single_counter: %0d bad cycles, required 0", cnt_err); end
    n_checks++; if (pix_count !== NP || pix_err !== 0 || exp_q.size() !== 0) begin n_fail++;
      $display("FAIL single_pixels: count=%0d errs=%0d left=%0d required %0d/0/0", pix_count, pix_err, exp_q.size(), NP); end
    n_checks++; if (last_index !== NP - 1) begin n_fail++;
      $display("FAIL single_last_index: got %0d required %0d", last_index, NP - 1); end
    n_checks++; if (overrun !== 1'b0 || underrun !== 1'b0) begin n_fail++;
      $display("FAIL single_flags: ovr=%b und=%b required 0/0", overrun, underrun); end
    n_checks++; if (state !== ST_IDLE || enable !== 1'b0) begin n_fail++;
      $display("FAIL single_idle: state=%0d enable=%b required IDLE/0", state, enable); end
  endtask

  task automatic test_extra_sample();
    run_line(16440, -1, -1, -1, LINE_CYC + 100);
    n_checks++; if (finished !== 1'b1) begin n_fail++; $display("FAIL extra_timeout: line did not end"); end
    n_checks++; if (extra_pv !== 0 || extra_idx !== NP - 1) begin n_fail++;
      $display("FAIL extra_dropped: pix_valid=%0d index=%0d required 0/%0d", extra_pv, extra_idx, NP - 1); end
    n_checks++; if (overrun !== 1'b1 || underrun !== 1'b0) begin n_fail++;
      $display("FAIL extra_flags: ovr=%b und=%b required 1/0", overrun, underrun); end
    n_checks++; if (pix_count !== NP || pix_err !== 0) begin n_fail++;
      $display("FAIL extra_pixels: count=%0d errs=%0d required %0d/0", pix_count, pix_err, NP); end
  endtask

  task automatic test_start_ignored_abort();
    run_line(-1, 1000, 500, -1, 3000);
    n_checks++; if (finished !== 1'b1) begin n_fail++; $display("FAIL abort_timeout: line did not end"); end
    n_checks++; if (cnt_err !== 0) begin n_fail++;
      $display("FAIL start_ignored: %0d counter disturbances, required 0", cnt_err); end
    n_checks++; if (done_cycles !== 1 || done_k[0] !== 1001 || busy_cycles !== 1002) begin n_fail++;
      $display("FAIL abort_done: count=%0d at=%0d busy=%0d required 1 at 1001 busy 1002", done_cycles, done_k[0], busy_cycles); end
    n_checks++; if (underrun !== 1'b1 || overrun !== 1'b0) begin n_fail++;
      $display("FAIL abort_flags: und=%b ovr=%b required 1/0", underrun, overrun); end
    n_checks++; if (pix_count !== 120 || pix_err !== 0) begin n_fail++;
      $display("FAIL abort_pixels: count=%0d errs=%0d required 120/0", pix_count, pix_err); end
    n_checks++; if (state !== ST_IDLE) begin n_fail++;
      $display("FAIL abort_idle: state=%0d required IDLE", state); end
  endtask

  task automatic test_flags_clear();
    @(negedge clk); adc_valid = 1'b1; adc_data = 12'h5a5;
    @(negedge clk); adc_valid = 1'b0;
    n_checks++; if (overrun !== 1'b1 || underrun !== 1'b1 || pix_valid !== 1'b0) begin n_fail++;
      $display("FAIL idle_sample: ovr=%b und=%b pv=%b required 1/1/0", overrun, underrun, pix_valid); end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_checks++; if (overrun !== 1'b0 || underrun !== 1'b0 || busy !== 1'b1) begin n_fail++;
      $display("FAIL start_clears: ovr=%b und=%b busy=%b required 0/0/1", overrun, underrun, busy); end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    n_checks++; if (done !== 1'b1 || underrun !== 1'b1 || enable !== 1'b0) begin n_fail++;
      $display("FAIL quick_abort: done=%b und=%b en=%b required 1/1/0", done, underrun, enable); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++;
      $display("FAIL quick_abort_idle: busy=%b done=%b required 0/0", busy, done); end
  endtask

  task automatic test_reset_midline();
    run_line(-1, -1, -1, 8000, 9000);
    n_checks++; if (finished !== 1'b1) begin n_fail++; $display("FAIL rst_timeout: reset point not reached"); end
    n_checks++; if (snap_enable !== 1'b0 || snap_busy !== 1'b0 || snap_done !== 1'b0 || snap_cnt !== 32'd0) begin n_fail++;
      $display("FAIL rst_async_ctrl: en=%b busy=%b done=%b cnt=%0d required 0", snap_enable, snap_busy, snap_done, snap_cnt); end
    n_checks++; if (snap_pv !== 1'b0 || snap_idx !== 11'd0 || snap_data !== '0 || snap_ovr !== 1'b0 || snap_und !== 1'b0) begin n_fail++;
      $display("FAIL rst_async_pix: pv=%b idx=%0d data=%0h ovr=%b und=%b required 0", snap_pv, snap_idx, snap_data, snap_ovr, snap_und); end
    n_checks++; if (done_cycles !== 0) begin n_fail++;
      $display("FAIL rst_no_done: got %0d done pulses required 0", done_cycles); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++;
      $display("FAIL rst_stays_idle: busy=%b done=%b required 0/0", busy, done); end
  endtask

  task automatic test_fresh_line();
    run_line(-1, -1, -1, -1, LINE_CYC + 100);
    n_checks++; if (finished !== 1'b1 || busy_cycles !== LINE_CYC || done_k[0] !== LINE_CYC - 1) begin n_fail++;
      $display("FAIL fresh_len: busy=%0d done_at=%0d required %0d/%0d", busy_cycles, done_k[0], LINE_CYC, LINE_CYC - 1); end
    n_checks++; if (pix_count !== NP || pix_err !== 0 || cnt_err !== 0) begin n_fail++;
      $display("FAIL fresh_pixels: count=%0d errs=%0d cnt_err=%0d required %0d/0/0", pix_count, pix_err, cnt_err, NP); end
    n_checks++; if (overrun !== 1'b0 || underrun !== 1'b0) begin n_fail++;
      $display("FAIL fresh_flags: ovr=%b und=%b required 0/0", overrun, underrun); end
  endtask

`ifdef READOUT_LINE_REPEAT_EN
  task automatic test_repeat();
    num_lines = 16'd3;
    run_line(-1, -1, -1, -1, 3 * LINE_CYC + 100);
    n_checks++; if (finished !== 1'b1 || busy_cycles !== 3 * LINE_CYC) begin n_fail++;
      $display("FAIL repeat_busy: busy=%0d required %0d", busy_cycles, 3 * LINE_CYC); end
    n_checks++; if (done_cycles !== 3 || done_k[0] !== LINE_CYC - 1 || done_k[1] - done_k[0] !== LINE_CYC || done_k[2] - done_k[1] !== LINE_CYC) begin n_fail++;
      $display("FAIL repeat_done: count=%0d at %0d %0d %0d", done_cycles, done_k[0], done_k[1], done_k[2]); end
    n_checks++; if (done_line[0] !== 0 || done_line[1] !== 1 || done_line[2] !== 2) begin n_fail++;
      $display("FAIL repeat_line_idx: got %0d %0d %0d required 0 1 2", done_line[0], done_line[1], done_line[2]); end
    n_checks++; if (pix_count !== 3 * NP || pix_err !== 0 || cnt_err !== 0 || underrun !== 1'b0) begin n_fail++;
      $display("FAIL repeat_pixels: count=%0d errs=%0d cnt_err=%0d und=%b", pix_count, pix_err, cnt_err, underrun); end
    num_lines = 16'd1;
  endtask
`endif

  initial begin
    test_reset();
    test_single_line();
    test_extra_sample();
    test_start_ignored_abort();
    test_flags_clear();
    test_reset_midline();
`ifdef READOUT_LINE_REPEAT_EN
    test_repeat();
`else
    test_fresh_line();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/readout_line_sequencer.md
# readout_line_sequencer

Line-readout controller for the imager front end. It runs the per-line cycle counter and enable that drive `analog_signal_generator`, and bounds each readout with a start/busy/done handshake. It also counts and tags the ADC samples returned during the pixel window, and flags protocol errors. It sits between the payload control registers and the ADC capture path.

## Interface
Parameters:
- `CICLOS_FORMAS_DE_ONDA`, default 8: clock cycles per pixel waveform period. Must match the generator instance.
- `N_PIXELS`, default 2048: pixels per line, and the expected ADC samples per line.
- `ADC_W`, default 12: ADC sample width.

Ports:
- `i_clock`, in, 1: system clock.
- `i_reset_n`, in, 1: asynchronous, active-low reset.
- `i_start`, in, 1: pulse that requests a line readout. Ignored unless IDLE.
- `i_abort`, in, 1: level. Terminates the readout in progress.
- `o_enable`, out, 1: drives the generator `i_enable`.
- `o_contador`, out, 32: drives the generator `contador`.
- `i_adc_valid`, in, 1: one-cycle strobe marking a converted sample.
- `i_adc_data`, in, ADC_W: sample, valid only with `i_adc_valid`.
- `o_pix_valid`, out, 1: registered sample strobe.
- `o_pix_data`, out, ADC_W: registered sample.
- `o_pix_index`, out, 11: pixel index of `o_pix_data`, from 0 to N_PIXELS-1.
- `o_busy`, out, 1: high from the accepted start until done.
- `o_done`, out, 1: one-cycle end-of-line pulse.
- `o_overrun`, out, 1: sticky. A sample arrived outside the window or beyond N_PIXELS.
- `o_underrun`, out, 1: sticky. The line ended with fewer than N_PIXELS samples.

## Operation
- Derived constants:
  - WIN_LO = 5·C−1.
  - WIN_HI = 2053·C.
  - LINE_LAST = 2058·C−1.
  - Here C = CICLOS_FORMAS_DE_ONDA.
- FSM states: IDLE, RUN, TAIL, DONE.
- IDLE:
  - `o_enable`=0 and `o_contador`=0.
  - `i_start`=1 moves to RUN and sets `o_busy`=1.
- RUN:
  - `o_enable`=1.
  - `o_contador` increments by 1 each cycle, starting at 0.
  - When `o_contador`==WIN_HI−1, the next state is TAIL.
- TAIL:
  - `o_enable` stays 1 and counting continues. The generator is already outside its window, so it emits no pulses.
  - This state covers ADC conversion latency.
  - When `o_contador`==LINE_LAST, the next state is DONE.
- DONE:
  - Lasts one cycle.
  - `o_done`=1, `o_enable`=0, `o_contador` returns to 0.
  - Next state is IDLE, where `o_busy` drops.
- Abort: `i_abort` in RUN or TAIL goes straight to DONE. `o_done` still pulses, and `o_underrun` is set if the sample count is below N_PIXELS.
- Sample capture, active only in RUN or TAIL:
  - If `i_adc_valid` arrives and pix_cnt < N_PIXELS: register the data, drive `o_pix_index` = pix_cnt, then increment pix_cnt.
  - If `i_adc_valid` arrives in IDLE or DONE, or when pix_cnt == N_PIXELS: set `o_overrun`. The sample is dropped.
- pix_cnt is 12 bits and saturates at N_PIXELS. It clears on an accepted start.
- `o_overrun` and `o_underrun` clear only on reset or on an accepted `i_start`.
- Reset values: all outputs 0, FSM in IDLE, counters 0.
- A reset mid-line returns to IDLE immediately. No `o_done` is produced.

## Timing
- From `i_start` sampled high to `o_enable`=1 is 1 cycle. `o_contador` is 0 in that first enabled cycle.
- Line length (default C=8):
  - `o_busy` is high for LINE_LAST+2 = 16465 cycles, counted as RUN+TAIL = 16464 cycles plus 1 DONE cycle.
  - `o_done` is high for exactly 1 cycle, on the last busy cycle.
- Sample path: `i_adc_valid` to `o_pix_valid` is 1 cycle, with no backpressure.
- `i_start` while busy is ignored, with no queuing.
- `i_start` and `i_abort` together in IDLE: start wins, and the abort is evaluated in the next cycle.

## Configuration
- `READOUT_LINE_REPEAT_EN`
- Defined:
  - Adds an input `i_num_lines` (16 bits) and an output `o_line_idx` (16 bits).
  - DONE returns to RUN, not IDLE, until `i_num_lines` lines have completed.
  - `o_done` pulses every line, and `o_busy` stays high across lines.
  - `i_num_lines`=0 behaves as 1.
  - Abort ends the whole sequence.
- Undefined: single line per `i_start`. The ports do not exist.

## Structure
- Package `readout_pkg`:
  - FSM state enum.
  - Constants WIN_LO, WIN_HI and LINE_LAST as functions of C.
  - Shared with `analog_signal_generator` so the window bounds are defined in one place.
- Natural sub-module: `readout_pixel_capture`. It holds pix_cnt, the sample register, and the overrun/underrun flags.

## Test plan
- Single line, with C=8 and an ADC model returning 1 sample per generator pulse: 2048 `o_pix_valid`, indices 0..2047, `o_done` at cycle 16465 after start, no flags set.
- `i_abort` at `o_contador`=1000: `o_done` on the next cycle, `o_underrun`=1, back to IDLE.
- One extra `i_adc_valid` in TAIL after 2048 samples: `o_overrun`=1, `o_pix_valid` stays low, `o_pix_index` stays at 2047.
- `i_start` pulsed at `o_contador`=500: no restart, `o_contador` unaffected. A new start after `o_done` clears both sticky flags.
- `i_reset_n` low at `o_contador`=8000: all outputs 0 asynchronously, no `o_done`. A later start behaves as a normal fresh line.
- With `READOUT_LINE_REPEAT_EN` and `i_num_lines`=3: three `o_done` pulses 16465 cycles apart, `o_busy` continuous, `o_line_idx` 0,1,2.
